// File: rtl/t05_huff_pkg.sv
// rtl/t05_huff_pkg.sv - shared constants and state encoding for the Huffman tree stage
package t05_huff_pkg;

    localparam int ADDR_W     = 9;
    localparam int DATA_W     = 64;
    localparam int LEAF_N     = 128;
    localparam int MAX_MERGES = 127;

    // Merged tree nodes are allocated upward from here, right after the leaves
    localparam logic [ADDR_W-1:0] NODE_BASE = ADDR_W'(LEAF_N);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_READ,
        S_DRAIN,
        S_BUILD,
        S_DONE
    } state_t;

endpackage

// File: rtl/t05_flv_sequencer_if.sv
// rtl/t05_flv_sequencer_if.sv - memory port, finder stream and tree builder handshake bundle
interface t05_flv_sequencer_if;
    import t05_huff_pkg::*;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    logic              flv_clr;
    logic              flv_valid;
    logic [ADDR_W-1:0] flv_index;
    logic [DATA_W-1:0] flv_value;

    logic              ht_start;
    logic              ht_done;
    logic              ht_wr_req;
    logic [ADDR_W-1:0] ht_wr_addr;
    logic [DATA_W-1:0] ht_wr_data;
    logic              ht_wr_gnt;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata,
        output flv_clr, flv_valid, flv_index, flv_value,
        output ht_start, ht_wr_gnt,
        input  ht_done, ht_wr_req, ht_wr_addr, ht_wr_data
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata,
        input  flv_clr, flv_valid, flv_index, flv_value,
        input  ht_start, ht_wr_gnt,
        output ht_done, ht_wr_req, ht_wr_addr, ht_wr_data
    );

endinterface

// File: rtl/t05_mem_port_mux.sv
// rtl/t05_mem_port_mux.sv - owner select of the shared memory port between scan reads and tree writes
module t05_mem_port_mux
    import t05_huff_pkg::*;
(
    input  logic              build,
    input  logic              scan_req,
    input  logic [ADDR_W-1:0] scan_addr,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              ack,
    output logic              req,
    output logic              we,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    output logic              wr_gnt
);

    // Outside BUILD the builder sees no grant, so its write simply waits
    always_comb begin
        req    = build ? wr_req : scan_req;
        we     = build;
        addr   = build ? wr_addr : (scan_req ? scan_addr : '0);
        wdata  = build ? wr_data : '0;
        wr_gnt = build & wr_req & ack;
    end

endmodule

// File: rtl/t05_flv_sequencer.sv
// rtl/t05_flv_sequencer.sv - repeated least-pair scan sequencer driving the finder and tree builder
module t05_flv_sequencer
    import t05_huff_pkg::*;
(
    input  logic                clk,
    input  logic                nrst,
    input  logic                start,
    t05_flv_sequencer_if.master bus,
    output logic                busy,
    output logic                htree_complete,
    output logic [7:0]          merge_cnt,
    output logic                err
);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] last_idx;
    logic [1:0]        live_cnt;
    logic              scan_req;
    logic              build;
    logic              scan_ack;
    logic              last_merge;

    // Each merge appends one node, so every pass scans one entry further
    assign last_idx       = NODE_BASE - ADDR_W'(1) + {{(ADDR_W-8){1'b0}}, merge_cnt};
    assign scan_ack       = (state == S_READ) && bus.mem_ack;
    assign last_merge     = (merge_cnt == 8'(MAX_MERGES - 1));
    assign busy           = (state != S_IDLE) && (state != S_DONE);
    assign htree_complete = (state == S_DONE);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        bus.flv_clr  = 1'b0;
        bus.ht_start = 1'b0;
        scan_req     = 1'b0;
        build        = 1'b0;
        case (state)
            S_IDLE, S_DONE: if (start) state_nxt = S_CLEAR;
            S_CLEAR: begin
                bus.flv_clr = 1'b1;
                state_nxt   = S_READ;
            end
            S_READ: begin
                scan_req = 1'b1;
                if (bus.mem_ack && idx == last_idx) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (live_cnt >= 2'd2) begin
                    bus.ht_start = 1'b1;
                    state_nxt    = S_BUILD;
                end else begin
                    state_nxt = S_DONE;
                end
            end
            S_BUILD: begin
                build = 1'b1;
                if (bus.ht_done) state_nxt = last_merge ? S_DONE : S_CLEAR;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            idx           <= '0;
            live_cnt      <= '0;
            merge_cnt     <= '0;
            err           <= 1'b0;
            bus.flv_valid <= 1'b0;
            bus.flv_index <= '0;
            bus.flv_value <= '0;
        end else begin
            bus.flv_valid <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        merge_cnt <= '0;
                        err       <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    idx      <= '0;
                    live_cnt <= '0;
                end
                S_READ: begin
                    if (scan_ack) begin
                        bus.flv_valid <= 1'b1;
                        bus.flv_index <= idx;
                        bus.flv_value <= bus.mem_rdata;
                        if (bus.mem_rdata != '0 && live_cnt != 2'd3) live_cnt <= live_cnt + 2'd1;
                        if (idx != last_idx) idx <= idx + ADDR_W'(1);
                    end
                end
                S_BUILD: begin
                    if (bus.ht_done) begin
                        merge_cnt <= merge_cnt + 8'd1;
                        if (last_merge) err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    t05_mem_port_mux u_mux (
        .build     (build),
        .scan_req  (scan_req),
        .scan_addr (idx),
        .wr_req    (bus.ht_wr_req),
        .wr_addr   (bus.ht_wr_addr),
        .wr_data   (bus.ht_wr_data),
        .ack       (bus.mem_ack),
        .req       (bus.mem_req),
        .we        (bus.mem_we),
        .addr      (bus.mem_addr),
        .wdata     (bus.mem_wdata),
        .wr_gnt    (bus.ht_wr_gnt)
    );

endmodule

// File: tb/tb_t05_flv_sequencer.sv
// tb/tb_t05_flv_sequencer.sv - directed self-checking bench for t05_flv_sequencer
module tb_t05_flv_sequencer;
    import t05_huff_pkg::*;

    logic       clk = 1'b0;
    logic       nrst;
    logic       start;
    logic       busy;
    logic       htree_complete;
    logic [7:0] merge_cnt;
    logic       err;

    t05_flv_sequencer_if bus ();

    t05_flv_sequencer dut (
        .clk            (clk),
        .nrst           (nrst),
        .start          (start),
        .bus            (bus),
        .busy           (busy),
        .htree_complete (htree_complete),
        .merge_cnt      (merge_cnt),
        .err            (err)
    );

    always #5 clk = ~clk;

    // Histogram written by the stimulus; tree writes land in wmem, valid for the current gen only
    logic [63:0] hist [0:511];
    logic [63:0] wmem [0:511];
    int          wtag [0:511];
    int          gen = 1;
    int          ack_delay = 0;

    int          flv_total = 0, hts_total = 0, clr_total = 0, order_bad = 0, stab_bad = 0;
    int          last_flv = 0, wait_cnt = 0;
    logic        prev_rd = 1'b0;
    logic [8:0]  prev_addr = '0;

    int checks = 0;
    int errors = 0;

    function automatic logic [63:0] rd(input int a);
        return (wtag[a] == gen) ? wmem[a] : hist[a];
    endfunction

    initial begin
        for (int i = 0; i < 512; i++) wtag[i] = 0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (bus.flv_valid) begin
                flv_total++;
                if (bus.flv_index != 0 && int'(bus.flv_index) != last_flv + 1) order_bad++;
                last_flv = int'(bus.flv_index);
            end
            if (bus.ht_start) hts_total++;
            if (bus.flv_clr) clr_total++;
            if (bus.mem_req && !bus.mem_we && prev_rd && !bus.mem_ack && bus.mem_addr != prev_addr) stab_bad++;
            prev_rd   = bus.mem_req && !bus.mem_we;
            prev_addr = bus.mem_addr;
            if (nrst && bus.mem_req) begin
                if (wait_cnt >= ack_delay) begin
                    bus.mem_ack = 1'b1;
                    wait_cnt    = 0;
                    if (bus.mem_we) begin
                        wmem[bus.mem_addr] = bus.mem_wdata;
                        wtag[bus.mem_addr] = gen;
                        bus.mem_rdata      = '0;
                    end else begin
                        bus.mem_rdata = rd(int'(bus.mem_addr));
                    end
                end else begin
                    bus.mem_ack   = 1'b0;
                    bus.mem_rdata = '0;
                    wait_cnt++;
                end
            end else begin
                bus.mem_ack   = 1'b0;
                bus.mem_rdata = '0;
                wait_cnt      = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_for(input int which, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            #2;
            if ((which == 0 && bus.ht_start) || (which == 1 && htree_complete) ||
                (which == 2 && bus.mem_req && bus.mem_addr == 9'd40)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_write(input logic [8:0] a, input logic [63:0] d);
        bit ok = 1'b0;
        bus.ht_wr_addr = a;
        bus.ht_wr_data = d;
        bus.ht_wr_req  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #2;
            if (bus.ht_wr_gnt) begin
                ok = 1'b1;
                break;
            end
        end
        chk("tree_write_gnt", 64'(ok), 64'd1);
        step();
        bus.ht_wr_req = 1'b0;
    endtask

    task automatic done_pulse();
        bus.ht_done = 1'b1;
        step();
        bus.ht_done = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, 64'({bus.mem_req, bus.mem_we, bus.mem_addr, bus.flv_clr, bus.flv_valid, bus.flv_index,
                      bus.ht_start, bus.ht_wr_gnt, busy, htree_complete, merge_cnt, err}), 64'd0);
        chk({tag, "_wdata"}, bus.mem_wdata, 64'd0);
        chk({tag, "_value"}, bus.flv_value, 64'd0);
    endtask

    initial begin
        bit ok;
        int b_flv, b_hts, b_clr, b_ord, b_stab;

        nrst           = 1'b0;
        start          = 1'b0;
        bus.ht_done    = 1'b0;
        bus.ht_wr_req  = 1'b0;
        bus.ht_wr_addr = '0;
        bus.ht_wr_data = '0;
        for (int i = 0; i < 512; i++) hist[i] = '0;
        #3;
        chk_all_zero("reset");
        step();
        step();
        nrst = 1'b1;
        step();
        chk("idle_complete", 64'(htree_complete), 64'd0);

        // Two live leaves: one merge, then a 129-entry rescan finds a single root
        hist[97] = 64'd5;
        hist[98] = 64'd3;
        b_flv = flv_total; b_hts = hts_total;
        pulse_start();
        chk("t1_busy", 64'(busy), 64'd1);
        wait_for(0, 400, ok);
        chk("t1_ht_start_seen", 64'(ok), 64'd1);
        chk("t1_flv_first_pass", 64'(flv_total - b_flv), 64'd128);
        step();
        do_write(9'd128, 64'd8);
        do_write(9'd97, 64'd0);
        do_write(9'd98, 64'd0);
        done_pulse();
        wait_for(1, 400, ok);
        chk("t1_complete_seen", 64'(ok), 64'd1);
        chk("t1_flv_both_passes", 64'(flv_total - b_flv), 64'd257);
        chk("t1_ht_start_count", 64'(hts_total - b_hts), 64'd1);
        chk("t1_merge_cnt", 64'(merge_cnt), 64'd1);
        chk("t1_err", 64'(err), 64'd0);
        chk("t1_busy_done", 64'(busy), 64'd0);

        // All-zero histogram
        gen++;
        hist[97] = '0;
        hist[98] = '0;
        b_flv = flv_total; b_hts = hts_total;
        pulse_start();
        wait_for(1, 400, ok);
        chk("t2_complete_seen", 64'(ok), 64'd1);
        chk("t2_flv_count", 64'(flv_total - b_flv), 64'd128);
        chk("t2_no_ht_start", 64'(hts_total - b_hts), 64'd0);
        chk("t2_merge_cnt", 64'(merge_cnt), 64'd0);

        // Slow memory: three wait cycles per read
        ack_delay = 3;
        b_flv = flv_total; b_ord = order_bad; b_stab = stab_bad;
        pulse_start();
        wait_for(1, 1000, ok);
        chk("t3_complete_seen", 64'(ok), 64'd1);
        chk("t3_flv_count", 64'(flv_total - b_flv), 64'd128);
        chk("t3_index_order", 64'(order_bad - b_ord), 64'd0);
        chk("t3_addr_stable", 64'(stab_bad - b_stab), 64'd0);
        chk("t3_last_index", 64'(last_flv), 64'd127);

        // Builder write held pending through the scan, plus start pulses in READ and BUILD
        ack_delay = 0;
        gen++;
        hist[97] = 64'd5;
        hist[98] = 64'd3;
        bus.ht_wr_addr = 9'd200;
        bus.ht_wr_data = 64'd77;
        bus.ht_wr_req  = 1'b1;
        b_flv = flv_total; b_clr = clr_total; b_ord = order_bad;
        pulse_start();
        for (int i = 0; i < 5; i++) step();
        @(negedge clk);
        #2;
        chk("t4_read_gnt", 64'(bus.ht_wr_gnt), 64'd0);
        chk("t4_read_we", 64'(bus.mem_we), 64'd0);
        chk("t4_read_addr", 64'(bus.mem_addr), 64'd4);
        pulse_start();
        chk("t4_start_in_read_busy", 64'(busy), 64'd1);
        wait_for(0, 400, ok);
        chk("t4_ht_start_seen", 64'(ok), 64'd1);
        chk("t4_flv_count", 64'(flv_total - b_flv), 64'd128);
        chk("t4_single_clear", 64'(clr_total - b_clr), 64'd1);
        chk("t4_index_order", 64'(order_bad - b_ord), 64'd0);
        chk("t4_write_stalled", rd(200), 64'd0);
        step();
        chk("t4_build_we", 64'(bus.mem_we), 64'd1);
        chk("t4_build_addr", 64'(bus.mem_addr), 64'd200);
        @(negedge clk);
        #2;
        chk("t4_build_gnt", 64'(bus.ht_wr_gnt), 64'd1);
        chk("t4_write_landed", rd(200), 64'd77);
        pulse_start();
        chk("t4_start_in_build_busy", 64'(busy), 64'd1);
        chk("t4_start_in_build_we", 64'(bus.mem_we), 64'd1);
        chk("t4_start_in_build_merges", 64'(merge_cnt), 64'd0);
        bus.ht_wr_req = 1'b0;
        do_write(9'd97, 64'd0);
        do_write(9'd98, 64'd0);
        done_pulse();
        wait_for(1, 400, ok);
        chk("t4_complete_seen", 64'(ok), 64'd1);
        chk("t4_merge_cnt", 64'(merge_cnt), 64'd1);

        // Asynchronous reset in the middle of a scan
        gen++;
        hist[97] = '0;
        hist[98] = '0;
        pulse_start();
        wait_for(2, 400, ok);
        chk("t5_reached_idx40", 64'(ok), 64'd1);
        nrst = 1'b0;
        #1;
        chk_all_zero("t5_async_reset");
        step();
        nrst = 1'b1;
        pulse_start();
        chk("t5_flv_clr", 64'(bus.flv_clr), 64'd1);
        step();
        chk("t5_rescan_req", 64'(bus.mem_req), 64'd1);
        chk("t5_rescan_addr", 64'(bus.mem_addr), 64'd0);
        wait_for(1, 400, ok);
        chk("t5_complete_seen", 64'(ok), 64'd1);

        // Builder that never retires entries: runs into the merge limit
        gen++;
        hist[5] = 64'd1;
        hist[6] = 64'd1;
        b_hts = hts_total;
        pulse_start();
        for (int i = 0; i < MAX_MERGES; i++) begin
            wait_for(0, 400, ok);
            chk("t6_ht_start_seen", 64'(ok), 64'd1);
            if (!ok) break;
            step();
            done_pulse();
            if (i == MAX_MERGES - 2) chk("t6_err_before_limit", 64'(err), 64'd0);
        end
        wait_for(1, 10, ok);
        chk("t6_complete_seen", 64'(ok), 64'd1);
        chk("t6_err", 64'(err), 64'd1);
        chk("t6_merge_cnt", 64'(merge_cnt), 64'd127);
        chk("t6_ht_start_count", 64'(hts_total - b_hts), 64'd127);
        pulse_start();
        chk("t6_err_cleared", 64'(err), 64'd0);
        chk("t6_merge_cleared", 64'(merge_cnt), 64'd0);
        chk("t6_restart_busy", 64'(busy), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
